// File: rtl/wvb_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wvb_reader_pkg
// Description : Shared types and helpers for the waveform buffer reader:
//               FSM state encoding, header word count, trailer tag and
//               end-of-waveform bit index.
// Revision    : 1.0 - initial release
// ============================================================================
package wvb_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Upper half of the optional trailer word
  localparam logic [15:0] c_trailer_tag = 16'hE0F0;

  // Number of output words needed to carry one header: ceil(hdr_w / out_w)
  function automatic int hdr_word_count(input int hdr_w, input int out_w);
    return (hdr_w + out_w - 1) / out_w;
  endfunction

  // The top bit of a waveform word carries the end-of-waveform flag
  function automatic int eoe_index(input int data_w);
    return data_w - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wvb_reader_skid.sv
`default_nettype none
// ============================================================================
// Module      : wvb_reader_skid
// Description : 2-entry valid/ready skid buffer. 'space' reports the number
//               of entries that can be accepted this cycle, counting a
//               same-cycle pop at the output, so an upstream reader can
//               schedule requests without stalling the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module wvb_reader_skid #(
  parameter int P_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] out_data,
  input  logic               out_ready,
  output logic [1:0]         space
);

  logic [1:0][P_WIDTH-1:0] mem_q, mem_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    w_push;
  logic                    w_pop;

  // Output comes straight from storage, so it cannot change while stalled
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign w_pop     = out_valid && out_ready;
  assign space     = 2'd2 - cnt_q + {1'b0, w_pop};
  assign in_ready  = (space != 2'd0);
  assign w_push    = in_valid && in_ready;

  // Next-state: write at the tail, advance the head on pop, track occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Storage and pointer registers; reset empties the buffer and zeroes data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wvb_reader.sv
`default_nettype none
// ============================================================================
// Module      : wvb_reader
// Description : Drains one buffered waveform at a time: pops the header,
//               emits it MSW first, streams zero-extended waveform words up
//               to the end-of-waveform flag (or the length limit), then
//               pulses wvb_rddone. Output is a valid/ready word stream.
//               Optional macro WVB_READER_TRAILER_EN appends a trailer word
//               {16'hE0F0, words_read[15:0]} before wvb_rddone.
// Revision    : 1.0 - initial release
// ============================================================================
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_OUT_WIDTH  = 32,
  parameter int P_MAX_LEN    = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_in,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data_in,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  output logic                    wvb_rdreq,
  output logic                    wvb_rddone,
  output logic [P_OUT_WIDTH-1:0]  dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic                    len_err
);

  localparam int          c_hdr_words = hdr_word_count(P_HDR_WIDTH, P_OUT_WIDTH);
  localparam int          c_hdr_bits  = c_hdr_words * P_OUT_WIDTH;
  localparam int          c_eoe       = eoe_index(P_DATA_WIDTH);
  localparam logic [15:0] c_max_len   = 16'(P_MAX_LEN);
  localparam logic [7:0]  c_hdr_last  = 8'(c_hdr_words - 1);

  state_e                  state_q, state_d;
  logic [c_hdr_bits-1:0]   hdr_q, hdr_d;        // shifts left one word per emit
  logic [7:0]              hdr_cnt_q, hdr_cnt_d;
  logic [15:0]             rd_cnt_q, rd_cnt_d;  // data words requested
  logic                    pend_q, pend_d;      // a read returns this cycle
  logic                    len_err_q, len_err_d;
  logic                    hdr_rdreq_q, hdr_rdreq_d;
`ifdef WVB_READER_TRAILER_EN
  logic                    trl_sent_q, trl_sent_d;
  logic [P_OUT_WIDTH-1:0]  w_trl;
`endif

  logic [c_hdr_bits-1:0]   w_hdr_ext;
  logic [P_OUT_WIDTH-1:0]  w_data_ext;
  logic                    w_eoe_in;
  logic                    w_last_read;
  logic                    w_force;
  logic [1:0]              w_need;
  logic                    w_push_valid;
  logic [P_OUT_WIDTH-1:0]  w_push_data;
  logic                    w_push_ready;
  logic [1:0]              w_space;

  assign w_eoe_in    = wvb_data_in[c_eoe];
  // The word returning when the count sits at the limit is the final one
  assign w_last_read = pend_q && (rd_cnt_q == c_max_len);
  assign w_force     = w_last_read && !w_eoe_in;
  // A returning word claims one slot, so a new read needs one more on top
  assign w_need      = pend_q ? 2'd2 : 2'd1;

  // Zero-pad the header at the MSB and zero-extend data, forcing EOE on abort
  always_comb begin
    w_hdr_ext                     = '0;
    w_hdr_ext[P_HDR_WIDTH-1:0]    = hdr_data_in;
    w_data_ext                    = '0;
    w_data_ext[P_DATA_WIDTH-1:0]  = wvb_data_in;
    if (w_force) begin
      w_data_ext[c_eoe] = 1'b1;
    end
  end

`ifdef WVB_READER_TRAILER_EN
  // Trailer word: tag in the upper half, data word count in the lower half
  always_comb begin
    w_trl        = '0;
    w_trl[31:0]  = {c_trailer_tag, rd_cnt_q};
  end
`endif

  // FSM next-state, request generation and output-stage push selection
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    hdr_cnt_d    = hdr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    pend_d       = 1'b0;
    len_err_d    = len_err_q;
    hdr_rdreq_d  = 1'b0;
`ifdef WVB_READER_TRAILER_EN
    trl_sent_d   = trl_sent_q;
`endif
    w_push_valid = 1'b0;
    w_push_data  = '0;
    wvb_rdreq    = 1'b0;
    wvb_rddone   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !hdr_empty) begin
          hdr_d       = w_hdr_ext;
          hdr_rdreq_d = 1'b1;
          hdr_cnt_d   = '0;
          rd_cnt_d    = '0;
`ifdef WVB_READER_TRAILER_EN
          trl_sent_d  = 1'b0;
`endif
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        w_push_valid = 1'b1;
        w_push_data  = hdr_q[c_hdr_bits-1 -: P_OUT_WIDTH];
        if (w_push_ready) begin
          hdr_d     = hdr_q << P_OUT_WIDTH;
          hdr_cnt_d = hdr_cnt_q + 8'd1;
          if (hdr_cnt_q == c_hdr_last) begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // A returning word always fits: its read was only issued with room
        w_push_valid = pend_q;
        w_push_data  = w_data_ext;
        if (pend_q && (w_eoe_in || w_last_read)) begin
          state_d = ST_DONE;
          if (w_force) begin
            len_err_d = 1'b1;
          end
        end else if ((rd_cnt_q != c_max_len) && (w_space >= w_need)) begin
          wvb_rdreq = 1'b1;
          pend_d    = 1'b1;
          rd_cnt_d  = rd_cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
`ifdef WVB_READER_TRAILER_EN
        if (!trl_sent_q) begin
          w_push_valid = 1'b1;
          w_push_data  = w_trl;
          if (w_push_ready) begin
            trl_sent_d = 1'b1;
          end
        end else if (!dout_valid) begin
          wvb_rddone = 1'b1;
          state_d    = ST_IDLE;
        end
`else
        if (!dout_valid) begin
          wvb_rddone = 1'b1;
          state_d    = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any waveform in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      hdr_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      pend_q      <= 1'b0;
      len_err_q   <= 1'b0;
      hdr_rdreq_q <= 1'b0;
`ifdef WVB_READER_TRAILER_EN
      trl_sent_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pend_q      <= pend_d;
      len_err_q   <= len_err_d;
      hdr_rdreq_q <= hdr_rdreq_d;
`ifdef WVB_READER_TRAILER_EN
      trl_sent_q  <= trl_sent_d;
`endif
    end
  end

  // Registered pop keeps hdr_rdreq low during reset; it lands on the first
  // HDR cycle, which is also when busy rises
  assign hdr_rdreq = hdr_rdreq_q;
  assign len_err   = len_err_q;
  assign busy      = (state_q != ST_IDLE) && !wvb_rddone;

  wvb_reader_skid #(
    .P_WIDTH (P_OUT_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_push_valid),
    .in_data   (w_push_data),
    .in_ready  (w_push_ready),
    .out_valid (dout_valid),
    .out_data  (dout),
    .out_ready (dout_ready),
    .space     (w_space)
  );

endmodule
`default_nettype wire

// File: tb/tb_wvb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wvb_reader
// Description : Self-checking bench for wvb_reader (P_MAX_LEN = 8). Models
//               the header FIFO (FWFT) and the waveform buffer (1-cycle read
//               latency); records output transfers and pulse timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wvb_reader;

  localparam int DW   = 22;
  localparam int HW   = 80;
  localparam int OW   = 32;
  localparam int MAXL = 8;
`ifdef WVB_READER_TRAILER_EN
  localparam int          TRL       = 1;
  localparam logic [31:0] EXP_T3_LAST = 32'hE0F0_0003;
`else
  localparam int          TRL       = 0;
  localparam logic [31:0] EXP_T3_LAST = 32'h0020_0333;
`endif
  localparam logic [HW-1:0] H1 = 80'h1234_5678_9ABC_DEF0_1122;
  localparam logic [HW-1:0] H2 = 80'hFFFF_0000_AAAA_5555_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] wvb_data_in;
  logic [HW-1:0] hdr_data_in;
  logic          hdr_empty;
  logic          hdr_rdreq;
  logic          wvb_rdreq;
  logic          wvb_rddone;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          len_err;

  always #5 clk = ~clk;

  wvb_reader #(
    .P_DATA_WIDTH (DW),
    .P_HDR_WIDTH  (HW),
    .P_OUT_WIDTH  (OW),
    .P_MAX_LEN    (MAXL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .wvb_data_in (wvb_data_in),
    .hdr_data_in (hdr_data_in),
    .hdr_empty   (hdr_empty),
    .hdr_rdreq   (hdr_rdreq),
    .wvb_rdreq   (wvb_rdreq),
    .wvb_rddone  (wvb_rddone),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .len_err     (len_err)
  );

  // ---------------- buffer models ----------------
  logic [DW-1:0] wmem [0:63];
  logic [HW-1:0] hmem [0:7];
  logic [5:0]    wptr;
  logic [2:0]    hrd;
  logic [2:0]    hwr;

  assign hdr_empty   = (hrd == hwr);
  assign hdr_data_in = hmem[hrd];

  // Waveform RAM returns data one cycle after the request; header FIFO pops
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      hrd         <= '0;
      wvb_data_in <= '0;
    end else begin
      if (wvb_rdreq) begin
        wvb_data_in <= wmem[wptr];
        wptr        <= wptr + 6'd1;
      end
      if (hdr_rdreq) hrd <= hrd + 3'd1;
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  int          cyc = 0;
  logic [31:0] got[$];
  int          got_cyc[$];
  int          hdr_cyc[$];
  int          done_cyc[$];
  bit          busy_hist[$];
  int          n_rd = 0;
  int          stab_viol = 0;
  bit          hold_q = 1'b0;
  logic [31:0] hold_dout = '0;

  always @(negedge clk) begin
    busy_hist.push_back(busy);
    if (rst_n) begin
      if (hold_q && !(dout_valid && dout == hold_dout)) stab_viol <= stab_viol + 1;
      if (dout_valid && dout_ready) begin
        got.push_back(dout);
        got_cyc.push_back(cyc);
      end
      if (hdr_rdreq)  hdr_cyc.push_back(cyc);
      if (wvb_rddone) done_cyc.push_back(cyc);
      if (wvb_rdreq)  n_rd <= n_rd + 1;
    end
    hold_q    <= rst_n && dout_valid && !dout_ready;
    hold_dout <= dout;
    cyc       <= cyc + 1;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit toggle   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (toggle) dout_ready = ~dout_ready;
    else        dout_ready = 1'b1;
  endtask

  task automatic hold_reset;
    rst_n      = 1'b0;
    toggle     = 1'b0;
    dout_ready = 1'b1;
    #1;
  endtask

  task automatic release_reset;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_cyc.size() < target && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(done_cyc.size() >= target), 64'd1);
  endtask

  function automatic logic [31:0] got_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 'x;
  endfunction

  // ---------------- vector table for the basic waveform ----------------
  typedef struct {
    bit          is_data;
    logic [21:0] wvb_in;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [0:7];
  int   n_vec;

  task automatic run_wave1(input bit tog, input string tag);
    int k, b_got, b_rd, b_hdr, b_done, b_viol;
    hold_reset();
    en      = 1'b0;
    hmem[0] = H1;
    hwr     = 3'd1;
    k = 0;
    for (int i = 0; i < n_vec; i++) begin
      if (vecs[i].is_data) begin
        wmem[k] = vecs[i].wvb_in;
        k++;
      end
    end
    wmem[k] = 22'h3F_FFFF;
    release_reset();
    b_got = got.size(); b_rd = n_rd; b_hdr = hdr_cyc.size();
    b_done = done_cyc.size(); b_viol = stab_viol;
    toggle = tog;
    en     = 1'b1;
    wait_done(b_done + 1, 300, {tag, " rddone seen"});
    repeat (6) tick();
    check({tag, " word count"}, 64'(got.size() - b_got), 64'(n_vec));
    for (int i = 0; i < n_vec; i++) begin
      check($sformatf("%s word %0d", tag, i), 64'(got_at(b_got + i)), 64'(vecs[i].exp_dout));
    end
    check({tag, " hdr_rdreq pulses"}, 64'(hdr_cyc.size() - b_hdr), 64'd1);
    check({tag, " rddone pulses"}, 64'(done_cyc.size() - b_done), 64'd1);
    check({tag, " reads issued"}, 64'(n_rd - b_rd), 64'd4);
    check({tag, " len_err"}, 64'(len_err), 64'd0);
    check({tag, " busy idle"}, 64'(busy), 64'd0);
    check({tag, " dout stable on stall"}, 64'(stab_viol - b_viol), 64'd0);
    if (!tog && got_cyc.size() >= b_got + 7) begin
      check({tag, " data burst span"}, 64'(got_cyc[b_got + 6] - got_cyc[b_got + 3]), 64'd3);
    end
  endtask

  initial begin
    int b_got, b_rd, b_hdr, b_done, low, k;
    bit seen;

    vecs[0] = '{1'b0, 22'h0,      32'h0000_1234};
    vecs[1] = '{1'b0, 22'h0,      32'h5678_9ABC};
    vecs[2] = '{1'b0, 22'h0,      32'hDEF0_1122};
    vecs[3] = '{1'b1, 22'h012345, 32'h0001_2345};
    vecs[4] = '{1'b1, 22'h0ABCDE, 32'h000A_BCDE};
    vecs[5] = '{1'b1, 22'h13FFFF, 32'h0013_FFFF};
    vecs[6] = '{1'b1, 22'h2000AA, 32'h0020_00AA};
    vecs[7] = '{1'b0, 22'h0,      32'hE0F0_0004};
    n_vec   = 7 + TRL;

    // Reset state: request pending and enabled, yet every output stays 0
    hold_reset();
    en      = 1'b1;
    hmem[0] = H1;
    hwr     = 3'd1;
    repeat (3) @(posedge clk);
    #2;
    check("reset outputs", 64'({dout, dout_valid, hdr_rdreq, wvb_rdreq, wvb_rddone, busy, len_err}), 64'd0);

    // Basic waveform, ready held high, then with ready toggling
    run_wave1(1'b0, "ready1");
    run_wave1(1'b1, "toggle");

    // Two waveforms back to back
    hold_reset();
    en = 1'b0;
    hmem[0] = H1; hmem[1] = H2; hwr = 3'd2;
    for (int i = 0; i < 4; i++) wmem[i] = vecs[3 + i].wvb_in;
    wmem[4] = 22'h000111; wmem[5] = 22'h000222; wmem[6] = 22'h200333; wmem[7] = 22'h3F_FFFF;
    release_reset();
    b_got = got.size(); b_hdr = hdr_cyc.size(); b_done = done_cyc.size();
    en = 1'b1;
    wait_done(b_done + 2, 400, "two rddone seen");
    repeat (6) tick();
    check("two hdr_rdreq pulses", 64'(hdr_cyc.size() - b_hdr), 64'd2);
    check("two word count", 64'(got.size() - b_got), 64'(13 + 2 * TRL));
    check("two second hdr word", 64'(got_at(b_got + 7 + TRL)), 64'h0000_FFFF);
    check("two last word", 64'(got_at(b_got + 12 + 2 * TRL)), 64'(EXP_T3_LAST));
    if (hdr_cyc.size() >= b_hdr + 2 && done_cyc.size() >= b_done + 2) begin
      check("turnaround after rddone", 64'(hdr_cyc[b_hdr + 1] > done_cyc[b_done]), 64'd1);
      low = 0;
      for (int c = hdr_cyc[b_hdr]; c < done_cyc[b_done + 1]; c++) if (!busy_hist[c]) low++;
      check("busy low only between", 64'(low), 64'(hdr_cyc[b_hdr + 1] - done_cyc[b_done]));
    end else begin
      check("two pulse records", 64'd0, 64'd1);
    end

    // Length guard: no EOE in the buffer
    hold_reset();
    en = 1'b0;
    hmem[0] = H1; hwr = 3'd1;
    for (int i = 0; i < 12; i++) wmem[i] = 22'h000100 + 22'(i);
    release_reset();
    b_got = got.size(); b_rd = n_rd; b_done = done_cyc.size();
    en = 1'b1;
    wait_done(b_done + 1, 300, "len rddone seen");
    repeat (6) tick();
    check("len word count", 64'(got.size() - b_got), 64'(11 + TRL));
    check("len 7th data word", 64'(got_at(b_got + 9)), 64'h0000_0106);
    check("len forced EOE word", 64'(got_at(b_got + 10)), 64'h0020_0107);
    check("len reads issued", 64'(n_rd - b_rd), 64'd8);
    check("len_err set", 64'(len_err), 64'd1);
    check("len rddone pulses", 64'(done_cyc.size() - b_done), 64'd1);
`ifdef WVB_READER_TRAILER_EN
    check("len trailer word", 64'(got_at(b_got + 11)), 64'hE0F0_0008);
`endif

    // Reset in the middle of DATA
    hold_reset();
    en = 1'b0;
    hmem[0] = H1; hwr = 3'd1;
    release_reset();
    en = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 50) begin
      tick();
      seen = wvb_rdreq;
      k++;
    end
    check("mid reached DATA", 64'(seen), 64'd1);
    b_hdr = hdr_cyc.size(); b_done = done_cyc.size();
    #2;
    rst_n = 1'b0;
    hwr   = 3'd0;
    #1;
    check("mid async reset outputs", 64'({dout, dout_valid, hdr_rdreq, wvb_rdreq, wvb_rddone, busy, len_err}), 64'd0);
    release_reset();
    repeat (10) tick();
    check("mid idle busy", 64'(busy), 64'd0);
    check("mid idle dout_valid", 64'(dout_valid), 64'd0);
    check("mid no header pop", 64'(hdr_cyc.size() - b_hdr), 64'd0);
    check("mid no rddone", 64'(done_cyc.size() - b_done), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
